// File: rtl/nibble_counter.sv
// nibble_counter: free-running modulo-N up/down counter with terminal count.
// Define NIBBLE_COUNTER_GRAY_EN to add the Gray-coded out_gray output.
`timescale 1ns/1ps
module nibble_counter #(
  parameter int unsigned     WIDTH   = 4,
  parameter longint unsigned MODULUS = longint'(1) << WIDTH,
  parameter longint unsigned STEP    = 1,
  parameter bit              DOWN    = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] out,
  output logic             tc
`ifdef NIBBLE_COUNTER_GRAY_EN
  ,
  output logic [WIDTH-1:0] out_gray
`endif
);

  localparam longint unsigned MAX_MOD = longint'(1) << WIDTH;

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("nibble_counter: WIDTH out of range 1..32");
  end
  if (MODULUS < 2 || MODULUS > MAX_MOD) begin : g_bad_mod
    $error("nibble_counter: MODULUS out of range 2..2**WIDTH");
  end
  if (STEP < 1 || STEP > MODULUS - 1) begin : g_bad_step
    $error("nibble_counter: STEP out of range 1..MODULUS-1");
  end

  localparam logic [WIDTH:0] MOD_V  = MODULUS[WIDTH:0];
  localparam logic [WIDTH:0] STEP_V = STEP[WIDTH:0];
  localparam logic [WIDTH:0] BACK_V = MOD_V - STEP_V;
  localparam logic [WIDTH:0] LAST_V = MOD_V - 1'b1;

  // Power-up value comes from the register initialiser, so no reset is needed.
  logic [WIDTH-1:0] count_q = '0;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH:0]   cur;
  logic [WIDTH:0]   sum;

  // Next count: one extra bit of headroom, then fold back into 0..MODULUS-1.
  always_comb begin
    cur     = {1'b0, count_q};
    sum     = cur + STEP_V;
    count_d = '0;
    if (cur >= MOD_V) begin
      count_d = '0;
    end else if (DOWN) begin
      if (cur >= STEP_V) begin
        count_d = WIDTH'(cur - STEP_V);
      end else begin
        count_d = WIDTH'(cur + BACK_V);
      end
    end else begin
      if (sum >= MOD_V) begin
        count_d = WIDTH'(sum - MOD_V);
      end else begin
        count_d = WIDTH'(sum);
      end
    end
  end

  // Count register; synchronous reset wins over counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign out = count_q;

  // Terminal count is a pure value decode of the current count.
  always_comb begin
    tc = 1'b0;
    if (DOWN) begin
      tc = (count_q == '0);
    end else begin
      tc = ({1'b0, count_q} == LAST_V);
    end
  end

`ifdef NIBBLE_COUNTER_GRAY_EN
  assign out_gray = count_q ^ (count_q >> 1);
`endif

endmodule

// File: tb/tb_nibble_counter.sv
// tb_nibble_counter: directed vector bench for three counter configurations.
// A = default up, B = DOWN mod 10, C = STEP 3 mod 16.
`timescale 1ns/1ps
module tb_nibble_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] a_out, b_out, c_out;
  logic       a_tc, b_tc, c_tc;
`ifdef NIBBLE_COUNTER_GRAY_EN
  logic [3:0] a_gray, b_gray, c_gray;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #50 clk = ~clk;

  nibble_counter u_a (
    .clk(clk), .reset(reset), .out(a_out), .tc(a_tc)
`ifdef NIBBLE_COUNTER_GRAY_EN
    , .out_gray(a_gray)
`endif
  );

  nibble_counter #(.MODULUS(10), .DOWN(1'b1)) u_b (
    .clk(clk), .reset(reset), .out(b_out), .tc(b_tc)
`ifdef NIBBLE_COUNTER_GRAY_EN
    , .out_gray(b_gray)
`endif
  );

  nibble_counter #(.STEP(3)) u_c (
    .clk(clk), .reset(reset), .out(c_out), .tc(c_tc)
`ifdef NIBBLE_COUNTER_GRAY_EN
    , .out_gray(c_gray)
`endif
  );

  typedef struct {
    logic       rst;
    logic [3:0] a;
    logic       ta;
    logic [3:0] b;
    logic       tb;
    logic [3:0] c;
  } vec_t;

  vec_t vt[26];

  function automatic vec_t mk(int r, int a, int ta, int b, int tb, int c);
    vec_t v;
    v.rst = 1'(r);
    v.a   = 4'(a);
    v.ta  = 1'(ta);
    v.b   = 4'(b);
    v.tb  = 1'(tb);
    v.c   = 4'(c);
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic chk_row(int i, vec_t v);
    chk("a_out", i, 32'(a_out), 32'(v.a));
    chk("a_tc",  i, 32'(a_tc),  32'(v.ta));
    chk("b_out", i, 32'(b_out), 32'(v.b));
    chk("b_tc",  i, 32'(b_tc),  32'(v.tb));
    chk("c_out", i, 32'(c_out), 32'(v.c));
`ifdef NIBBLE_COUNTER_GRAY_EN
    chk("a_gray", i, 32'(a_gray), 32'(v.a ^ (v.a >> 1)));
    chk("b_gray", i, 32'(b_gray), 32'(v.b ^ (v.b >> 1)));
    chk("c_gray", i, 32'(c_gray), 32'(v.c ^ (v.c >> 1)));
`endif
  endtask

  initial begin
    vt[0]  = mk(0,  1, 0, 9, 0,  3);
    vt[1]  = mk(0,  2, 0, 8, 0,  6);
    vt[2]  = mk(0,  3, 0, 7, 0,  9);
    vt[3]  = mk(0,  4, 0, 6, 0, 12);
    vt[4]  = mk(0,  5, 0, 5, 0, 15);
    vt[5]  = mk(0,  6, 0, 4, 0,  2);
    vt[6]  = mk(0,  7, 0, 3, 0,  5);
    vt[7]  = mk(0,  8, 0, 2, 0,  8);
    vt[8]  = mk(0,  9, 0, 1, 0, 11);
    vt[9]  = mk(0, 10, 0, 0, 1, 14);
    vt[10] = mk(0, 11, 0, 9, 0,  1);
    vt[11] = mk(0, 12, 0, 8, 0,  4);
    vt[12] = mk(0, 13, 0, 7, 0,  7);
    vt[13] = mk(0, 14, 0, 6, 0, 10);
    vt[14] = mk(0, 15, 1, 5, 0, 13);
    vt[15] = mk(0,  0, 0, 4, 0,  0);
    vt[16] = mk(0,  1, 0, 3, 0,  3);
    vt[17] = mk(0,  2, 0, 2, 0,  6);
    vt[18] = mk(0,  3, 0, 1, 0,  9);
    vt[19] = mk(0,  4, 0, 0, 1, 12);
    vt[20] = mk(0,  5, 0, 9, 0, 15);
    vt[21] = mk(0,  6, 0, 8, 0,  2);
    vt[22] = mk(0,  7, 0, 7, 0,  5);
    vt[23] = mk(1,  0, 0, 0, 1,  0);
    vt[24] = mk(0,  1, 0, 9, 0,  3);
    vt[25] = mk(0,  2, 0, 8, 0,  6);

    // Power-up state before any edge, reset never asserted.
    #10;
    chk_row(-1, mk(0, 0, 0, 0, 1, 0));

    for (int i = 0; i < 26; i++) begin
      reset = vt[i].rst;
      @(posedge clk);
      #10;
      chk_row(i, vt[i]);
      if (i == 9) begin
        chk("a_at_950ns", i, 32'(a_out), 32'd10);
      end
    end

    // Reset held for two edges, then released: first count equals STEP.
    reset = 1'b1;
    @(posedge clk);
    #10;
    chk_row(100, mk(1, 0, 0, 0, 1, 0));
    @(posedge clk);
    #10;
    chk_row(101, mk(1, 0, 0, 0, 1, 0));
    reset = 1'b0;
    @(posedge clk);
    #10;
    chk_row(102, mk(0, 1, 0, 9, 0, 3));
    @(posedge clk);
    #10;
    chk_row(103, mk(0, 2, 0, 8, 0, 6));
`ifdef NIBBLE_COUNTER_GRAY_EN
    chk("c_gray_of_6", 103, 32'(c_gray), 32'd5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
